// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: pipeline writes win,
// buffered responses drain into free slots. Define REGFILE_WB_BYPASS_EN for 0-cycle response bypass.
module regfile_wb_arbiter #(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int fifo_els_p        = 4,
    parameter int starve_limit_p    = 8,
    parameter bit x0_tied_to_zero_p = 1'b1,
    localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     pipe_v_i,
    input  logic [addr_width_lp-1:0] pipe_addr_i,
    input  logic [width_p-1:0]       pipe_data_i,

    input  logic                     rsp_v_i,
    input  logic [addr_width_lp-1:0] rsp_addr_i,
    input  logic [width_p-1:0]       rsp_data_i,
    output logic                     rsp_ready_o,

    output logic                     w_v_o,
    output logic [addr_width_lp-1:0] w_addr_o,
    output logic [width_p-1:0]       w_data_o,

    output logic                     stall_pipe_o,
    output logic                     fifo_empty_o
);

    localparam int ptr_width_lp    = $clog2(fifo_els_p);
    localparam int cnt_width_lp    = $clog2(fifo_els_p + 1);
    localparam int starve_width_lp = $clog2(starve_limit_p + 1);

    localparam logic [ptr_width_lp-1:0]    ptr_last_lp   = ptr_width_lp'(fifo_els_p - 1);
    localparam logic [cnt_width_lp-1:0]    cnt_full_lp   = cnt_width_lp'(fifo_els_p);
    localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

    logic [ptr_width_lp-1:0]    rptr_q, wptr_q;
    logic [cnt_width_lp-1:0]    count_q, count_d;
    logic [starve_width_lp-1:0] starve_cnt_q, starve_cnt_d;

    logic [addr_width_lp-1:0] mem_addr [fifo_els_p];
    logic [width_p-1:0]       mem_data [fifo_els_p];

    logic fifo_empty;
    logic pipe_to_x0;
    logic rsp_to_x0;
    logic pipe_fire;
    logic bypass;
    logic push;
    logic pop;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
        return (ptr == ptr_last_lp) ? '0 : ptr + 1'b1;
    endfunction

    // Handshake-side flags come from registered state only.
    assign fifo_empty   = (count_q == '0);
    assign fifo_empty_o = fifo_empty;
    assign rsp_ready_o  = (count_q != cnt_full_lp);
    assign stall_pipe_o = (starve_cnt_q == starve_max_lp);

    assign pipe_to_x0 = x0_tied_to_zero_p && (pipe_addr_i == '0);
    assign rsp_to_x0  = x0_tied_to_zero_p && (rsp_addr_i == '0);

    // A discarded x0 pipe write leaves the port free for the FIFO head.
    assign pipe_fire = ~reset_i & pipe_v_i & ~stall_pipe_o & ~pipe_to_x0;

`ifdef REGFILE_WB_BYPASS_EN
    assign bypass = ~reset_i & fifo_empty & ~pipe_fire & rsp_v_i & ~rsp_to_x0;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = ~pipe_fire & ~fifo_empty;
    assign push = rsp_v_i & rsp_ready_o & ~rsp_to_x0 & ~bypass;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        w_v_o    = 1'b0;
        w_addr_o = '0;
        w_data_o = '0;
        if (pipe_fire) begin
            w_v_o    = 1'b1;
            w_addr_o = pipe_addr_i;
            w_data_o = pipe_data_i;
        end else if (!fifo_empty) begin
            w_v_o    = ~reset_i;
            w_addr_o = mem_addr[rptr_q];
            w_data_o = mem_data[rptr_q];
        end else if (bypass) begin
            w_v_o    = 1'b1;
            w_addr_o = rsp_addr_i;
            w_data_o = rsp_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Counts cycles a buffered response waits without reaching the port.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != starve_max_lp) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // NOTE: storage has no reset; count_q guards every read, so stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wptr_q] <= rsp_addr_i;
            mem_data[wptr_q] <= rsp_data_i;
        end
    end

endmodule
